pingpong_window_reader: RTL

//  Read side of the ping-pong line buffer: once the writer completes a bank of NUM_LINES lines,

---
 rtl/cnn_lb_pkg.sv | 14 +
 rtl/window_shift_reg.sv | 32 +++
 rtl/pingpong_window_reader.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/cnn_lb_pkg.sv
// Shared types for the line-buffer read side: FSM states, default address width,
// and the window element index helper.
package cnn_lb_pkg;

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, RELEASE} rd_state_e;

  localparam int ADDR_WIDTH_DEF = 14;

  // Flat index of window element (row r, column c); c=0 is the oldest column.
  function automatic int win_idx(input int r, input int c, input int k);
    return r * k + c;
  endfunction

endpackage

// File: rtl/window_shift_reg.sv
// K x K column shift register: each shift drops the oldest column (c=0) and appends
// col_in (or a zero column when zero_in) at c=K-1.
module window_shift_reg
  import cnn_lb_pkg::*;
#(
  parameter int K  = 3,
  parameter int DW = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              shift_en,
  input  logic              zero_in,
  input  logic [K*DW-1:0]   col_in,
  output logic [K*K*DW-1:0] win_out
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      win_out <= '0;
    end else if (clr) begin
      win_out <= '0;
    end else if (shift_en) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++)
          win_out[win_idx(r, c, K)*DW +: DW] <= win_out[win_idx(r, c + 1, K)*DW +: DW];
        win_out[win_idx(r, K - 1, K)*DW +: DW] <= zero_in ? '0 : col_in[r*DW +: DW];
      end
    end
  end

endmodule

// File: rtl/pingpong_window_reader.sv
// Ping-pong line buffer read side: sweeps a completed bank column by column and streams
// K x K windows over valid/ready. Optional horizontal zero padding under ZERO_PAD_EN.
module pingpong_window_reader
  import cnn_lb_pkg::*;
#(
  parameter int NUM_LINES  = 3,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  bank_ready,
  input  logic                                  bank_sel,
  input  logic [ADDR_WIDTH-1:0]                 line_width,
  output logic                                  rd_en,
  output logic                                  rd_bank,
  output logic [ADDR_WIDTH-1:0]                 rd_addr,
  input  logic [NUM_LINES*DATA_WIDTH-1:0]       rd_data,
  output logic                                  win_valid,
  input  logic                                  win_ready,
  output logic [NUM_LINES*NUM_LINES*DATA_WIDTH-1:0] win_data,
  output logic                                  win_eol,
  output logic                                  bank_release,
  output logic                                  busy
);

  localparam int K  = NUM_LINES;
  localparam int DW = DATA_WIDTH;
  localparam int CW = ADDR_WIDTH + 2;
`ifdef ZERO_PAD_EN
  localparam int PAD = (K - 1) / 2;
`else
  localparam int PAD = 0;
`endif
  localparam logic [CW-1:0] K_C   = CW'(K);
  localparam logic [CW-1:0] PAD_C = CW'(PAD);

  rd_state_e         state;
  logic [ADDR_WIDTH-1:0] lw_q;
  logic              data_pend, col_buf_vld;
  logic [K*DW-1:0]   col_buf, col_src;
  logic [CW-1:0]     col_cnt, col_nxt, total, lw_ext;
  logic              skip, can_shift, have_col, pad_tail, shift, clr, last_hs;

  assign lw_ext    = {2'b00, lw_q};
  // Virtual column stream length, including leading/trailing pad columns.
  assign total     = lw_ext + (PAD_C << 1);
  assign col_nxt   = col_cnt + CW'(1);
  assign can_shift = !win_valid || win_ready;
  assign have_col  = col_buf_vld || data_pend;
  assign col_src   = col_buf_vld ? col_buf : rd_data;
  assign clr       = (state == IDLE) && bank_ready;
  assign last_hs   = win_valid && win_ready && win_eol;

`ifdef ZERO_PAD_EN
  assign skip     = (lw_q == '0);
  assign pad_tail = (state == DRAIN) && !have_col && (col_cnt >= lw_ext + PAD_C) && (col_cnt < total);
`else
  assign skip     = (lw_ext < K_C);
  assign pad_tail = 1'b0;
`endif

  assign shift = can_shift && (have_col || pad_tail);
  assign rd_en = (state == STREAM) && !skip && can_shift;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      lw_q         <= '0;
      rd_addr      <= '0;
      rd_bank      <= 1'b0;
      bank_release <= 1'b0;
      busy         <= 1'b0;
    end else begin
      bank_release <= 1'b0;
      case (state)
        IDLE: if (bank_ready) begin
          state   <= STREAM;
          busy    <= 1'b1;
          rd_bank <= bank_sel;
          lw_q    <= line_width;
          rd_addr <= '0;
        end
        STREAM: begin
          if (skip) begin
            state        <= RELEASE;
            bank_release <= 1'b1;
          end else if (rd_en) begin
            rd_addr <= rd_addr + ADDR_WIDTH'(1);
            if (rd_addr == lw_q - ADDR_WIDTH'(1)) state <= DRAIN;
          end
        end
        DRAIN: if (last_hs) begin
          state        <= RELEASE;
          bank_release <= 1'b1;
        end
        RELEASE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // One-column skid: a read issued just before a stall lands here until the window drains.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_pend   <= 1'b0;
      col_buf_vld <= 1'b0;
      col_buf     <= '0;
      col_cnt     <= '0;
      win_valid   <= 1'b0;
      win_eol     <= 1'b0;
    end else begin
      data_pend <= rd_en;
      if (col_buf_vld) begin
        if (shift) begin
          col_buf_vld <= data_pend;
          col_buf     <= rd_data;
        end
      end else if (data_pend && !can_shift) begin
        col_buf_vld <= 1'b1;
        col_buf     <= rd_data;
      end

      if (clr)        col_cnt <= PAD_C;
      else if (shift) col_cnt <= col_nxt;

      if (shift) begin
        win_valid <= (col_nxt >= K_C);
        win_eol   <= (col_nxt == total);
      end else if (win_ready) begin
        win_valid <= 1'b0;
        win_eol   <= 1'b0;
      end
    end
  end

  window_shift_reg #(.K(K), .DW(DW)) u_win (
    .clk      (clk),
    .reset    (reset),
    .clr      (clr),
    .shift_en (shift),
    .zero_in  (pad_tail),
    .col_in   (col_src),
    .win_out  (win_data)
  );

endmodule
